// File: rtl/ofmap_writer_pkg.sv
// -----------------------------------------------------------------------------
// Config: shared parameters and types for the systolic-array output path.
//   sys_cols      : lanes per partial-sum row
//   P_BITWIDTH    : signed partial-sum width coming out of the array
//   OUT_BITWIDTH  : signed requantized output lane width
//   ACC_BITWIDTH  : accumulator width (P_BITWIDTH + 8, room for 256 tiles)
//   ofw_state_e   : ofmap_writer control states
//   acc_row_t     : one accumulator row
// -----------------------------------------------------------------------------
package Config;

  localparam int sys_cols     = 4;
  localparam int P_BITWIDTH   = 16;
  localparam int OUT_BITWIDTH = 8;
  localparam int ACC_BITWIDTH = P_BITWIDTH + 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ofw_state_e;

  typedef logic signed [sys_cols-1:0][ACC_BITWIDTH-1:0] acc_row_t;

endpackage

// File: rtl/ofmap_writer_if.sv
// -----------------------------------------------------------------------------
// ofmap_writer_if: bundles the configuration, partial-sum stream, output
// stream and status signals of ofmap_writer.
//   cfg_start/cfg_num_tiles/cfg_shift/cfg_relu_en : tile configuration
//   psum_valid/psum_data/psum_ready               : partial-sum input stream
//   of_valid/of_data/of_last/of_ready             : requantized output stream
//   busy/done                                     : status
// Modports: slave = the writer block, master = whoever drives it.
// -----------------------------------------------------------------------------
interface ofmap_writer_if
  import Config::*;
#(
  parameter int OUT_BITWIDTH = Config::OUT_BITWIDTH
);

  logic                                      cfg_start;
  logic [7:0]                                cfg_num_tiles;
  logic [4:0]                                cfg_shift;
  logic                                      cfg_relu_en;

  logic                                      psum_valid;
  logic [sys_cols-1:0][P_BITWIDTH-1:0]       psum_data;
  logic                                      psum_ready;

  logic                                      of_valid;
  logic [sys_cols-1:0][OUT_BITWIDTH-1:0]     of_data;
  logic                                      of_last;
  logic                                      of_ready;

  logic                                      busy;
  logic                                      done;

  modport slave (
    input  cfg_start, cfg_num_tiles, cfg_shift, cfg_relu_en,
    input  psum_valid, psum_data,
    output psum_ready,
    output of_valid, of_data, of_last,
    input  of_ready,
    output busy, done
  );

  modport master (
    output cfg_start, cfg_num_tiles, cfg_shift, cfg_relu_en,
    output psum_valid, psum_data,
    input  psum_ready,
    input  of_valid, of_data, of_last,
    output of_ready,
    input  busy, done
  );

endinterface

// File: rtl/ofmap_writer_requant.sv
// -----------------------------------------------------------------------------
// requant_lane: combinational requantization of one accumulator lane.
//   lane_i    : signed ACC_BITWIDTH accumulated value
//   shift_i   : arithmetic right-shift amount
//   relu_en_i : clamp negative values to zero before shifting
//   lane_o    : signed OUT_BITWIDTH saturated result
// Order: ReLU, round half up, arithmetic shift, saturate.
// -----------------------------------------------------------------------------
module requant_lane
  import Config::*;
#(
  parameter int OUT_BITWIDTH = Config::OUT_BITWIDTH
) (
  input  logic signed [ACC_BITWIDTH-1:0] lane_i,
  input  logic        [4:0]              shift_i,
  input  logic                           relu_en_i,
  output logic        [OUT_BITWIDTH-1:0] lane_o
);

  // A 64-bit working width keeps the rounding constant (up to 2^30) from
  // overflowing regardless of the accumulator width.
  localparam logic signed [63:0] OUT_MAX = (64'sd1 <<< (OUT_BITWIDTH-1)) - 64'sd1;
  localparam logic signed [63:0] OUT_MIN = -(64'sd1 <<< (OUT_BITWIDTH-1));

  logic signed [63:0] relu_v;
  logic signed [63:0] rounded_v;
  logic signed [63:0] shifted_v;

  always_comb begin
    relu_v = {{(64-ACC_BITWIDTH){lane_i[ACC_BITWIDTH-1]}}, lane_i};
    if (relu_en_i && lane_i[ACC_BITWIDTH-1]) begin
      relu_v = '0;
    end

    rounded_v = relu_v;
    if (shift_i != 5'd0) begin
      rounded_v = relu_v + (64'sd1 <<< (shift_i - 5'd1));
    end

    shifted_v = rounded_v >>> shift_i;

    if (shifted_v > OUT_MAX) begin
      lane_o = OUT_MAX[OUT_BITWIDTH-1:0];
    end else if (shifted_v < OUT_MIN) begin
      lane_o = OUT_MIN[OUT_BITWIDTH-1:0];
    end else begin
      lane_o = shifted_v[OUT_BITWIDTH-1:0];
    end
  end

endmodule

// File: rtl/ofmap_writer.sv
// -----------------------------------------------------------------------------
// ofmap_writer: accumulates ROWS partial-sum rows over cfg_num_tiles input
// channel tiles, then requantizes and streams the rows out.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : ofmap_writer_if.slave (config, psum stream, output stream, status)
// Parameters:
//   ROWS         : rows per output tile (buffer depth)
//   OUT_BITWIDTH : signed output lane width
// -----------------------------------------------------------------------------
module ofmap_writer
  import Config::*;
#(
  parameter int ROWS         = 16,
  parameter int OUT_BITWIDTH = Config::OUT_BITWIDTH
) (
  input  logic           clk,
  input  logic           rst,
  ofmap_writer_if.slave  bus
);

  localparam int              PTR_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(ROWS - 1);

  ofw_state_e state_q, state_d;

  logic [7:0]       num_tiles_q;
  logic [4:0]       shift_q;
  logic             relu_q;
  logic [PTR_W-1:0] row_ptr_q;
  logic [7:0]       tile_cnt_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             rd_done_q;

  acc_row_t         acc_buf_q [ROWS];
  acc_row_t         ext_row;
  acc_row_t         rd_row;

  logic                                  of_valid_q;
  logic [sys_cols-1:0][OUT_BITWIDTH-1:0] of_data_q;
  logic                                  of_last_q;
  logic [sys_cols-1:0][OUT_BITWIDTH-1:0] rq_row;

  logic psum_ready;
  logic busy;
  logic done;
  logic psum_hs;
  logic last_beat;
  logic out_load;
  logic last_out_hs;

  // cfg_num_tiles = 0 wraps to 255 here, which makes the last tile index 255,
  // i.e. 256 tiles in total.
  assign psum_hs     = psum_ready && bus.psum_valid;
  assign last_beat   = psum_hs && (row_ptr_q == LAST_ROW) &&
                       (tile_cnt_q == (num_tiles_q - 8'd1));
  assign out_load    = !of_valid_q || bus.of_ready;
  assign last_out_hs = of_valid_q && bus.of_ready && of_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cfg_start) state_d = ACCUM;
      ACCUM:   if (last_beat)     state_d = DRAIN;
      DRAIN:   if (last_out_hs)   state_d = DONE;
      DONE:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    psum_ready = (state_q == ACCUM);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
  end

  // Control and output-stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_tiles_q <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      row_ptr_q   <= '0;
      tile_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      rd_done_q   <= 1'b0;
      of_valid_q  <= 1'b0;
      of_data_q   <= '0;
      of_last_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.cfg_start) begin
        num_tiles_q <= bus.cfg_num_tiles;
        shift_q     <= bus.cfg_shift;
        relu_q      <= bus.cfg_relu_en;
        row_ptr_q   <= '0;
        tile_cnt_q  <= '0;
        rd_ptr_q    <= '0;
        rd_done_q   <= 1'b0;
      end

      if (psum_hs) begin
        if (row_ptr_q == LAST_ROW) begin
          row_ptr_q  <= '0;
          tile_cnt_q <= tile_cnt_q + 8'd1;
        end else begin
          row_ptr_q  <= row_ptr_q + PTR_W'(1);
        end
      end

      // Once every row has been issued, the next free slot just drops valid.
      if (state_q == DRAIN && out_load) begin
        if (!rd_done_q) begin
          of_valid_q <= 1'b1;
          of_data_q  <= rq_row;
          of_last_q  <= (rd_ptr_q == LAST_ROW);
          if (rd_ptr_q == LAST_ROW) begin
            rd_done_q <= 1'b1;
          end else begin
            rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
          end
        end else begin
          of_valid_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    ext_row = '0;
    for (int l = 0; l < sys_cols; l++) begin
      ext_row[l] = {{(ACC_BITWIDTH-P_BITWIDTH){bus.psum_data[l][P_BITWIDTH-1]}},
                    bus.psum_data[l]};
    end
  end

  // The first tile overwrites the row, so no clear pass is needed between
  // output tiles; buffer contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (psum_hs) begin
      for (int l = 0; l < sys_cols; l++) begin
        if (tile_cnt_q == 8'd0) begin
          acc_buf_q[row_ptr_q][l] <= ext_row[l];
        end else begin
          acc_buf_q[row_ptr_q][l] <= acc_buf_q[row_ptr_q][l] + ext_row[l];
        end
      end
    end
  end

  assign rd_row = acc_buf_q[rd_ptr_q];

  for (genvar g = 0; g < sys_cols; g++) begin : g_rq
    requant_lane #(
      .OUT_BITWIDTH (OUT_BITWIDTH)
    ) u_requant (
      .lane_i    (rd_row[g]),
      .shift_i   (shift_q),
      .relu_en_i (relu_q),
      .lane_o    (rq_row[g])
    );
  end

  assign bus.psum_ready = psum_ready;
  assign bus.of_valid   = of_valid_q;
  assign bus.of_data    = of_data_q;
  assign bus.of_last    = of_last_q;
  assign bus.busy       = busy;
  assign bus.done       = done;

endmodule

// File: tb/tb_ofmap_writer.sv
// -----------------------------------------------------------------------------
// tb_ofmap_writer: self-checking bench for ofmap_writer with ROWS = 4 and
// OUT_BITWIDTH = 8. Expected output rows are pushed into a scoreboard queue
// when a tile is started and popped by the output monitor on each handshake.
// -----------------------------------------------------------------------------
module tb_ofmap_writer;
  import Config::*;

  localparam int ROWS = 4;
  localparam int OBW  = 8;
  localparam int COLS = sys_cols;

  typedef struct packed {
    logic [COLS*OBW-1:0] data;
    logic                last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ofmap_writer_if #(.OUT_BITWIDTH(OBW)) bus ();

  ofmap_writer #(
    .ROWS         (ROWS),
    .OUT_BITWIDTH (OBW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycleCnt    = 0;
  int   rxCount     = 0;
  int   lastHsEdge  = -1;
  int   pat [ROWS][COLS];
  exp_t expQ [$];

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Output monitor: every handshake pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.of_valid && bus.of_ready) begin
      rxCount    = rxCount + 1;
      lastHsEdge = cycleCnt + 1;
      testsRun   = testsRun + 1;
      if (expQ.size() == 0) begin
        testsFailed = testsFailed + 1;
        $display("[TB] FAIL unexpected_row: got data=%h last=%b, expected no row",
                 bus.of_data, bus.of_last);
      end else begin
        e = expQ.pop_front();
        if (bus.of_data !== e.data || bus.of_last !== e.last) begin
          testsFailed = testsFailed + 1;
          $display("[TB] FAIL row_%0d: got data=%h last=%b, expected data=%h last=%b",
                   rxCount, bus.of_data, bus.of_last, e.data, e.last);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int requantModel(longint v, int sh, bit relu);
    longint x;
    x = v;
    if (relu && x < 0) x = 0;
    if (sh > 0) x = x + (longint'(1) <<< (sh - 1));
    x = x >>> sh;
    if (x > 127)  x = 127;
    if (x < -128) x = -128;
    return int'(x);
  endfunction

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic setPatAll(input int v0, input int v1, input int v2, input int v3);
    for (int r = 0; r < ROWS; r++) begin
      pat[r][0] = v0; pat[r][1] = v1; pat[r][2] = v2; pat[r][3] = v3;
    end
  endtask

  // Runs one complete output tile: config, accumulation, drain and done.
  task automatic runTile(input int nt, input int sh, input bit relu,
                         input bit gaps, input bit backpress, input bit checkLatency);
    int   effNt;
    int   w;
    int   rx0;
    exp_t e;
    logic [COLS*OBW-1:0] held;
    effNt = (nt == 0) ? 256 : nt;

    for (int r = 0; r < ROWS; r++) begin
      for (int l = 0; l < COLS; l++) begin
        e.data[l*OBW +: OBW] = OBW'(requantModel(longint'(effNt) * pat[r][l], sh, relu));
      end
      e.last = (r == ROWS - 1);
      expQ.push_back(e);
    end

    rx0               = rxCount;
    bus.cfg_num_tiles = 8'(nt);
    bus.cfg_shift     = 5'(sh);
    bus.cfg_relu_en   = relu;
    bus.cfg_start     = 1'b1;
    stepClk();
    bus.cfg_start     = 1'b0;

    testsRun++;
    if (bus.busy !== 1'b1 || bus.psum_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL start_latency: got busy=%b psum_ready=%b, expected 1 1",
               bus.busy, bus.psum_ready);
    end

    for (int t = 0; t < effNt; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (gaps && ((t * ROWS + r) % 3 == 1)) begin
          bus.psum_valid = 1'b0;
          bus.cfg_start  = 1'b1;
          bus.cfg_shift  = 5'(sh + 3);
          stepClk();
          stepClk();
          bus.cfg_start  = 1'b0;
          bus.cfg_shift  = 5'(sh);
        end
        bus.psum_valid = 1'b1;
        for (int l = 0; l < COLS; l++) bus.psum_data[l] = 16'(pat[r][l]);
        w = 0;
        while (!bus.psum_ready && w < 20) begin
          stepClk();
          w++;
        end
        if (!bus.psum_ready) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL psum_accept: got psum_ready=0 at beat %0d, expected 1",
                   t * ROWS + r);
          bus.psum_valid = 1'b0;
          expQ.delete();
          return;
        end
        stepClk();
      end
    end
    bus.psum_valid = 1'b0;

    testsRun++;
    if (bus.psum_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL accum_end: got psum_ready=%b, expected 0", bus.psum_ready);
    end

    if (checkLatency) begin
      testsRun++;
      if (bus.of_valid !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL drain_latency0: got of_valid=%b, expected 0", bus.of_valid);
      end
      stepClk();
      testsRun++;
      if (bus.of_valid !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL drain_latency1: got of_valid=%b, expected 1", bus.of_valid);
      end
    end

    if (backpress) begin
      w = 0;
      while (rxCount < rx0 + 1 && w < 20) begin
        stepClk();
        w++;
      end
      bus.of_ready = 1'b0;
      held         = bus.of_data;
      for (int c = 0; c < 5; c++) begin
        stepClk();
        testsRun++;
        if (bus.of_valid !== 1'b1 || bus.of_data !== held) begin
          testsFailed++;
          $display("[TB] FAIL backpressure_hold: got valid=%b data=%h, expected valid=1 data=%h",
                   bus.of_valid, bus.of_data, held);
        end
      end
      bus.of_ready = 1'b1;
    end

    w = 0;
    while (bus.done !== 1'b1 && w < 40) begin
      stepClk();
      w++;
    end
    testsRun++;
    if (bus.done !== 1'b1 || cycleCnt != lastHsEdge) begin
      testsFailed++;
      $display("[TB] FAIL done_timing: got done=%b at cycle %0d, expected done=1 at cycle %0d",
               bus.done, cycleCnt, lastHsEdge);
    end
    stepClk();
    testsRun++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL done_pulse: got done=%b busy=%b, expected 0 0", bus.done, bus.busy);
    end
    testsRun++;
    if (expQ.size() != 0 || rxCount != rx0 + ROWS) begin
      testsFailed++;
      $display("[TB] FAIL row_count: got %0d rows (%0d pending), expected %0d rows",
               rxCount - rx0, expQ.size(), ROWS);
      expQ.delete();
    end
  endtask

  task automatic test_reset();
    rst               = 1'b1;
    bus.cfg_start     = 1'b0;
    bus.cfg_num_tiles = '0;
    bus.cfg_shift     = '0;
    bus.cfg_relu_en   = 1'b0;
    bus.psum_valid    = 1'b0;
    bus.psum_data     = '0;
    bus.of_ready      = 1'b1;
    repeat (3) stepClk();
    testsRun++;
    if (bus.psum_ready !== 1'b0 || bus.of_valid !== 1'b0 || bus.of_last !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_handshake: got psum_ready=%b of_valid=%b of_last=%b, expected 0 0 0",
               bus.psum_ready, bus.of_valid, bus.of_last);
    end
    testsRun++;
    if (bus.of_data !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: got %h, expected 0", bus.of_data);
    end
    testsRun++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_status: got busy=%b done=%b, expected 0 0", bus.busy, bus.done);
    end
    rst = 1'b0;
    stepClk();
  endtask

  task automatic test_single_tile();
    setPatAll(5, -3, 127, -128);
    runTile(1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_multi_tile();
    setPatAll(100, 100, 100, 100);
    runTile(3, 2, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation_relu();
    pat[0] = '{1000, -1000, 6, -6};
    pat[1] = '{-1000, 1000, -6, 6};
    pat[2] = '{0, 1, -1, 2};
    pat[3] = '{32767, -32768, 3, -3};
    runTile(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    runTile(1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    runTile(1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < COLS; l++) pat[r][l] = r * 10 + l;
    runTile(1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_num_tiles_zero();
    setPatAll(1, -1, 2, -2);
    runTile(0, 4, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps_cfg_ignore();
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < COLS; l++) pat[r][l] = (l % 2 == 0) ? (7 * r + l + 3) : -(5 * r + l);
    runTile(2, 1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_accum();
    setPatAll(50, 50, 50, 50);
    bus.cfg_num_tiles = 8'd2;
    bus.cfg_shift     = 5'd0;
    bus.cfg_relu_en   = 1'b0;
    bus.cfg_start     = 1'b1;
    stepClk();
    bus.cfg_start     = 1'b0;
    for (int r = 0; r < 2; r++) begin
      bus.psum_valid = 1'b1;
      for (int l = 0; l < COLS; l++) bus.psum_data[l] = 16'(pat[r][l]);
      stepClk();
    end
    bus.psum_valid = 1'b0;
    rst = 1'b1;
    #1;
    testsRun++;
    if (bus.psum_ready !== 1'b0 || bus.of_valid !== 1'b0 || bus.of_last !== 1'b0 ||
        bus.of_data !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset: got ready=%b valid=%b last=%b data=%h busy=%b done=%b, expected all 0",
               bus.psum_ready, bus.of_valid, bus.of_last, bus.of_data, bus.busy, bus.done);
    end
    stepClk();
    rst = 1'b0;
    stepClk();
    setPatAll(-9, 13, 60, -70);
    runTile(1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_saturation_relu();
    test_backpressure();
    test_num_tiles_zero();
    test_gaps_cfg_ignore();
    test_reset_mid_accum();
    repeat (2) stepClk();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ofmap_writer.md
# ofmap_writer

Output-feature-map stage directly downstream of the systolic-array top. It accepts one row of `sys_cols` partial sums per beat and accumulates them in a local buffer across `cfg_num_tiles` input-channel tiles. It then requantizes every row (optional ReLU, rounding arithmetic shift, saturation to `OUT_BITWIDTH`) and drains the rows out on a valid/ready stream toward the output memory.

## Interface
Parameters:
- `ROWS`, default 16: partial-sum rows per output tile; this is the buffer depth.
- `OUT_BITWIDTH`, default 8: signed output lane width.
- `sys_cols`, `P_BITWIDTH`, `ACC_BITWIDTH`: taken from package `Config`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_start`  in  1  starts a new output tile. Sampled only in IDLE; it latches the three `cfg_*` fields below.
- `cfg_num_tiles`  in  8  number of input-channel tiles to accumulate. 0 means 256.
- `cfg_shift`  in  5  right-shift amount for requantization.
- `cfg_relu_en`  in  1  clamp negatives to 0 before the shift.
- `psum_valid`  in  1  a partial-sum row is present on `psum_data`.
- `psum_data`  in  `[sys_cols-1:0][P_BITWIDTH-1:0]`  signed partial sums.
- `psum_ready`  out  1  the block accepts a row this cycle.
- `of_valid`  out  1  an output row is valid.
- `of_data`  out  `[sys_cols-1:0][OUT_BITWIDTH-1:0]`  requantized row.
- `of_last`  out  1  marks row `ROWS-1` of the drain.
- `of_ready`  in  1  downstream accepts the output row.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after the last output handshake.

## Operation
States: IDLE → ACCUM → DRAIN → DONE → IDLE.

IDLE:
- `cfg_start` = 1 latches the configuration, clears `row_ptr` and `tile_cnt`, and moves to ACCUM.

ACCUM:
- `psum_ready` = 1.
- On each handshake, `buf[row_ptr]` receives the incoming row.
  - When `tile_cnt` = 0 the row is written directly (sign-extended to `ACC_BITWIDTH`). No buffer clear is needed.
  - Otherwise the row is added per lane to the stored value.
- `row_ptr` increments. At `ROWS-1` it wraps to 0 and `tile_cnt` increments.
- The handshake that completes row `ROWS-1` of the last tile moves the state to DRAIN.

Arithmetic:
- `ACC_BITWIDTH` = `P_BITWIDTH` + 8. With at most 256 tiles the sum cannot overflow, so no saturation is applied in the accumulator.

DRAIN:
- `rd_ptr` walks 0..`ROWS-1`. Each lane passes through the `requant_lane` function:
  - ReLU, if enabled: negative values become 0.
  - Rounding: if `cfg_shift` > 0, add `1 << (cfg_shift-1)`, i.e. round half up.
  - Arithmetic right shift by `cfg_shift`.
  - Saturate to the range [-2^(OUT_BITWIDTH-1), 2^(OUT_BITWIDTH-1)-1].
- The result is registered into the output stage.
- The output register loads when `!of_valid || of_ready`.
- While `of_valid` = 1 and `of_ready` = 0, `of_data` and `of_last` hold stable.
- The handshake with `of_last` = 1 moves the state to DONE.

DONE:
- `done` = 1 for one cycle, then the state returns to IDLE.

Boundary rules:
- `cfg_start` outside IDLE is ignored.
- `psum_valid` outside ACCUM is not accepted, because `psum_ready` = 0.
- `rst` asserted mid-operation forces IDLE immediately, with all outputs at their reset values. Buffer contents are don't-care.

## Timing
- Reset values: `psum_ready` = 0, `of_valid` = 0, `of_data` = 0, `of_last` = 0, `busy` = 0, `done` = 0.
- `cfg_start` sampled in cycle N gives `busy` and `psum_ready` high in cycle N+1.
- Accumulation sustains one row per cycle with no bubbles.
- The ACCUM→DRAIN transition happens on the final accept edge. The first `of_valid` appears 1 cycle after entering DRAIN because the buffer read is registered.
- With `of_ready` held high, the drain delivers one row per cycle; `ROWS` rows take `ROWS` cycles after that first-row latency.
- `done` asserts the cycle after the `of_last` handshake. `busy` falls in the same cycle that `done` falls.

## Structure
Package `Config` additions:
- `OUT_BITWIDTH`.
- `ACC_BITWIDTH` = `P_BITWIDTH` + 8.
- Typedef `ofw_state_e` with values {IDLE, ACCUM, DRAIN, DONE}.
- Typedef `acc_row_t` = `logic signed [sys_cols-1:0][ACC_BITWIDTH-1:0]`.

Sub-module:
- `requant_lane` is purely combinational: one `ACC_BITWIDTH` lane plus `shift` and `relu_en` in, `OUT_BITWIDTH` out.
- It is instantiated `sys_cols` times inside `ofmap_writer`.
- The buffer is an inferred register array in `ofmap_writer`.

## Test plan
Run with `ROWS` = 4 and `OUT_BITWIDTH` = 8.

1. Single tile, no shift, no ReLU. Rows 0..3 with every lane = {5, -3, 127, -128}. Expect `of_data` lanes = {5, -3, 127, -128}, `of_last` on the 4th row, and `done` one cycle later.
2. Three tiles, each lane = 100 every beat, `cfg_shift` = 2. Accumulated 300; (300 + 2) >> 2 = 75 on all lanes and rows.
3. Saturation and ReLU:
   - Lane sum 1000 with shift 0 gives 127.
   - Lane sum -1000 gives -128 with ReLU off and 0 with ReLU on.
   - Sum 6 with shift 2 gives 2; sum -6 with shift 2 gives -1.
4. Backpressure: hold `of_ready` = 0 for 5 cycles mid-drain. Row 1 data and `of_valid` stay stable, no row is lost or duplicated, and the row order is 0,1,2,3.
5. Control corner cases:
   - `cfg_num_tiles` = 0: accepts exactly 1024 beats before DRAIN.
   - `psum_valid` gaps: the accumulated result is unchanged.
   - `cfg_start` during ACCUM is ignored.
6. Reset mid-ACCUM after 2 beats: all outputs return to 0 and the state goes to IDLE. A fresh single-tile run then produces the correct values, with no carry-over from the aborted tile.
